// File: rtl/arm7tdmi_mem_arbiter_if.sv
// Bundle of the core-side request/response signals and the external
// memory bus seen by the ARM7TDMI memory arbiter.
// The "master" modport is the arbiter's view, because it masters the memory bus.
// The "slave" modport is the view of the surrounding core pipeline and memory model.
interface arm7tdmi_mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_thumb;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        if_abort;

    logic        d_req;
    logic        d_we;
    logic        d_byte;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_abort;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        input  if_req, if_addr, if_thumb,
        output if_ack, if_rdata, if_abort,
        input  d_req, d_we, d_byte, d_addr, d_wdata,
        output d_ack, d_rdata, d_abort,
        output mem_addr, mem_wdata, mem_re, mem_we, mem_be,
        input  mem_rdata, mem_ready
    );

    modport slave (
        output if_req, if_addr, if_thumb,
        input  if_ack, if_rdata, if_abort,
        output d_req, d_we, d_byte, d_addr, d_wdata,
        input  d_ack, d_rdata, d_abort,
        input  mem_addr, mem_wdata, mem_re, mem_we, mem_be,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/arm7tdmi_mem_arbiter.sv
// Single-port memory bus arbiter for the ARM7TDMI fetch unit and load/store
// datapath. Data normally wins contention; a starvation counter forces a
// fetch grant after STARVE_MAX consecutive fetch losses. The bus is fully
// registered, byte lanes are steered for LDR/STR/LDRB/STRB and Thumb fetch,
// and an access that waits TIMEOUT_CYCLES bus cycles is aborted.
module arm7tdmi_mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int STARVE_MAX     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    arm7tdmi_mem_arbiter_if.master        bus
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0] STARVE_LIMIT = SW'(STARVE_MAX);

    state_t        state_q, state_d;
    logic [TW-1:0] timeout_cnt;
    logic [SW-1:0] starve_cnt;

    logic          cur_fetch;
    logic          cur_thumb;
    logic          cur_we;
    logic          cur_byte;
    logic [1:0]    cur_lane;

    logic          any_req;
    logic          grant_fetch;
    logic          bus_timeout;
    logic          win_we;
    logic [31:0]   win_addr;
    logic [31:0]   win_wdata;
    logic [3:0]    win_be;
    logic [31:0]   steered;

    // Arbitration decision and next-state logic
    always_comb begin
        state_d     = state_q;
        any_req     = bus.if_req | bus.d_req;
        grant_fetch = bus.if_req & (~bus.d_req | (starve_cnt == STARVE_LIMIT));
        bus_timeout = ~bus.mem_ready & (timeout_cnt == TIMEOUT_LAST);
        case (state_q)
            IDLE: if (any_req) state_d = BUS;
            BUS:  if (bus.mem_ready | bus_timeout) state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus image of the winning request: aligned address, lane enables, replicated store data
    always_comb begin
        win_we    = 1'b0;
        win_addr  = bus.if_addr;
        win_wdata = '0;
        win_be    = 4'hF;
        if (grant_fetch) begin
            if (bus.if_thumb) win_be = bus.if_addr[1] ? 4'b1100 : 4'b0011;
        end else begin
            win_we   = bus.d_we;
            win_addr = bus.d_addr;
            if (bus.d_byte) begin
                win_be    = 4'b0001 << bus.d_addr[1:0];
                win_wdata = {4{bus.d_wdata[7:0]}};
            end else begin
                win_wdata = bus.d_wdata;
            end
        end
    end

    // Read data steering: Thumb halfword, zero-extended byte, or ARM rotated word
    always_comb begin
        steered = '0;
        if (cur_fetch) begin
            if (cur_thumb) steered = cur_lane[1] ? {16'h0, bus.mem_rdata[31:16]}
                                                 : {16'h0, bus.mem_rdata[15:0]};
            else           steered = bus.mem_rdata;
        end else if (cur_byte) begin
            case (cur_lane)
                2'd0: steered = {24'h0, bus.mem_rdata[7:0]};
                2'd1: steered = {24'h0, bus.mem_rdata[15:8]};
                2'd2: steered = {24'h0, bus.mem_rdata[23:16]};
                default: steered = {24'h0, bus.mem_rdata[31:24]};
            endcase
        end else begin
            case (cur_lane)
                2'd0: steered = bus.mem_rdata;
                2'd1: steered = {bus.mem_rdata[7:0],  bus.mem_rdata[31:8]};
                2'd2: steered = {bus.mem_rdata[15:0], bus.mem_rdata[31:16]};
                default: steered = {bus.mem_rdata[23:0], bus.mem_rdata[31:24]};
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Registered bus, responses, latched request and the timeout/starvation counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_re    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_be    <= '0;
            bus.if_ack    <= 1'b0;
            bus.if_rdata  <= '0;
            bus.if_abort  <= 1'b0;
            bus.d_ack     <= 1'b0;
            bus.d_rdata   <= '0;
            bus.d_abort   <= 1'b0;
            cur_fetch     <= 1'b0;
            cur_thumb     <= 1'b0;
            cur_we        <= 1'b0;
            cur_byte      <= 1'b0;
            cur_lane      <= '0;
            timeout_cnt   <= '0;
            starve_cnt    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        bus.mem_addr  <= {win_addr[31:2], 2'b00};
                        bus.mem_wdata <= win_wdata;
                        bus.mem_be    <= win_be;
                        bus.mem_re    <= ~win_we;
                        bus.mem_we    <= win_we;
                        cur_fetch     <= grant_fetch;
                        cur_thumb     <= bus.if_thumb;
                        cur_we        <= win_we;
                        cur_byte      <= bus.d_byte;
                        cur_lane      <= win_addr[1:0];
                        timeout_cnt   <= '0;
                        if (bus.if_req && bus.d_req) begin
                            if (grant_fetch)                  starve_cnt <= '0;
                            else if (starve_cnt != STARVE_LIMIT) starve_cnt <= starve_cnt + 1'b1;
                        end else if (bus.if_req) begin
                            starve_cnt <= '0;
                        end
                    end
                end
                BUS: begin
                    if (bus.mem_ready || bus_timeout) begin
                        bus.mem_addr  <= '0;
                        bus.mem_wdata <= '0;
                        bus.mem_be    <= '0;
                        bus.mem_re    <= 1'b0;
                        bus.mem_we    <= 1'b0;
                        timeout_cnt   <= '0;
                        if (cur_fetch) begin
                            bus.if_ack   <= 1'b1;
                            bus.if_abort <= ~bus.mem_ready;
                            bus.if_rdata <= bus.mem_ready ? steered : '0;
                        end else begin
                            bus.d_ack   <= 1'b1;
                            bus.d_abort <= ~bus.mem_ready;
                            bus.d_rdata <= (bus.mem_ready && !cur_we) ? steered : '0;
                        end
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end
                RESP: begin
                    bus.if_ack   <= 1'b0;
                    bus.if_rdata <= '0;
                    bus.if_abort <= 1'b0;
                    bus.d_ack    <= 1'b0;
                    bus.d_rdata  <= '0;
                    bus.d_abort  <= 1'b0;
                    timeout_cnt  <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_arm7tdmi_mem_arbiter.sv
// Directed bench for the ARM7TDMI memory arbiter: a vector table of single
// accesses with lane steering, then hand-written sequences for starvation,
// wait states, timeout abort and reset in the middle of an access.
module tb_arm7tdmi_mem_arbiter;

    logic clk;
    logic rst;

    arm7tdmi_mem_arbiter_if ifc();

    arm7tdmi_mem_arbiter #(.TIMEOUT_CYCLES(16), .STARVE_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    // Core clock, 10 time units
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word array, stall counter and preload port
    logic [31:0] mem [0:4095];
    int          stall_req;
    int          bus_cnt;
    bit          stuck;
    bit          pre_en;
    logic [31:0] pre_addr;
    logic [31:0] pre_val;

    assign ifc.mem_rdata = mem[ifc.mem_addr[13:2]];
    assign ifc.mem_ready = (ifc.mem_re | ifc.mem_we) && (bus_cnt >= stall_req) && !stuck;

    // Counts not-ready bus cycles so the bench can insert wait states
    always @(posedge clk) begin
        if ((ifc.mem_re || ifc.mem_we) && !ifc.mem_ready) bus_cnt <= bus_cnt + 1;
        else                                              bus_cnt <= 0;
    end

    // Memory writes under byte enables, plus bench preloads
    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_addr[13:2]] <= pre_val;
        end else if (ifc.mem_we && ifc.mem_ready) begin
            for (int b = 0; b < 4; b++)
                if (ifc.mem_be[b]) mem[ifc.mem_addr[13:2]][8*b +: 8] <= ifc.mem_wdata[8*b +: 8];
        end
    end

    typedef struct {
        bit          fetch;
        bit          thumb;
        bit          we;
        bit          byte_op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] preload;
        logic [31:0] exp_mem_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_mem_wdata;
        logic [31:0] exp_rdata;
        logic [31:0] exp_mem_after;
    } vec_t;

    vec_t vecs[10];
    int   checks;
    int   failures;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic preloadWord(input logic [31:0] addr, input logic [31:0] val);
        @(negedge clk);
        pre_en   = 1'b1;
        pre_addr = addr;
        pre_val  = val;
        @(posedge clk);
        #1;
        pre_en   = 1'b0;
    endtask

    task automatic waitAck(input int limit, output int cycles, output bit seen);
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < limit) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (ifc.if_ack || ifc.d_ack) seen = 1'b1;
        end
    endtask

    task automatic clearReqs();
        ifc.if_req   = 1'b0;
        ifc.if_addr  = '0;
        ifc.if_thumb = 1'b0;
        ifc.d_req    = 1'b0;
        ifc.d_we     = 1'b0;
        ifc.d_byte   = 1'b0;
        ifc.d_addr   = '0;
        ifc.d_wdata  = '0;
    endtask

    task automatic issueLoad(input logic [31:0] addr);
        ifc.d_req  = 1'b1;
        ifc.d_we   = 1'b0;
        ifc.d_byte = 1'b0;
        ifc.d_addr = addr;
    endtask

    // One table vector: drive request, check bus image in cycle 1, check ack in cycle 2
    task automatic applyStimulus(input vec_t v, input int idx);
        int cycles;
        bit seen;
        string tag;
        tag = $sformatf("vec%0d", idx);
        preloadWord({v.addr[31:2], 2'b00}, v.preload);
        @(negedge clk);
        if (v.fetch) begin
            ifc.if_req   = 1'b1;
            ifc.if_addr  = v.addr;
            ifc.if_thumb = v.thumb;
        end else begin
            ifc.d_req   = 1'b1;
            ifc.d_we    = v.we;
            ifc.d_byte  = v.byte_op;
            ifc.d_addr  = v.addr;
            ifc.d_wdata = v.wdata;
        end
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, "_strobes"}, {30'h0, ifc.mem_re, ifc.mem_we}, v.we ? 32'h1 : 32'h2);
        checkOutput({tag, "_mem_addr"}, ifc.mem_addr, v.exp_mem_addr);
        checkOutput({tag, "_mem_be"}, {28'h0, ifc.mem_be}, {28'h0, v.exp_be});
        if (v.we) checkOutput({tag, "_mem_wdata"}, ifc.mem_wdata, v.exp_mem_wdata);
        waitAck(1, cycles, seen);
        if (v.fetch) begin
            checkOutput({tag, "_if_ack"}, {31'h0, ifc.if_ack}, 32'h1);
            checkOutput({tag, "_d_ack_idle"}, {31'h0, ifc.d_ack}, 32'h0);
            checkOutput({tag, "_if_abort"}, {31'h0, ifc.if_abort}, 32'h0);
            checkOutput({tag, "_if_rdata"}, ifc.if_rdata, v.exp_rdata);
        end else begin
            checkOutput({tag, "_d_ack"}, {31'h0, ifc.d_ack}, 32'h1);
            checkOutput({tag, "_if_ack_idle"}, {31'h0, ifc.if_ack}, 32'h0);
            checkOutput({tag, "_d_abort"}, {31'h0, ifc.d_abort}, 32'h0);
            if (v.we) checkOutput({tag, "_mem_after"}, mem[v.exp_mem_addr[13:2]], v.exp_mem_after);
            else      checkOutput({tag, "_d_rdata"}, ifc.d_rdata, v.exp_rdata);
        end
        checkOutput({tag, "_resp_strobes"}, {30'h0, ifc.mem_re, ifc.mem_we}, 32'h0);
        clearReqs();
    endtask

    initial begin
        int  cycles;
        bit  seen;
        bit  stray_ack;
        bit  got_fetch;

        checks    = 0;
        failures  = 0;
        stall_req = 0;
        stuck     = 1'b0;
        pre_en    = 1'b0;
        pre_addr  = '0;
        pre_val   = '0;
        clearReqs();

        //            fetch thumb we byte addr          wdata         preload       mem_addr      be       mem_wdata     rdata         mem_after
        vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h1004, 32'hAABBCCDD, 32'h00000000, 32'h1004, 4'b1111, 32'hAABBCCDD, 32'h0,        32'hAABBCCDD};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h1016, 32'h0,        32'h11223344, 32'h1014, 4'b0100, 32'h0,        32'h00000022, 32'h0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h1015, 32'h0,        32'h11223344, 32'h1014, 4'b1111, 32'h0,        32'h44112233, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h1013, 32'h000000AB, 32'h11223344, 32'h1010, 4'b1000, 32'hABABABAB, 32'h0,        32'hAB223344};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000, 32'h0,        32'hE5910008, 32'h0000, 4'b0011, 32'h0,        32'h00000008, 32'h0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0003, 32'h0,        32'hE5910008, 32'h0000, 4'b1100, 32'h0,        32'h0000E591, 32'h0};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0008, 32'h0,        32'h12345678, 32'h0008, 4'b1111, 32'h0,        32'h12345678, 32'h0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h1022, 32'h0,        32'hAABBCCDD, 32'h1020, 4'b1111, 32'h0,        32'hCCDDAABB, 32'h0};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h1021, 32'h0,        32'hAABBCCDD, 32'h1020, 4'b0010, 32'h0,        32'h000000CC, 32'h0};
        vecs[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h1033, 32'h01020304, 32'h55555555, 32'h1030, 4'b1111, 32'h01020304, 32'h0,        32'h01020304};

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_flags", {26'h0, ifc.if_ack, ifc.if_abort, ifc.d_ack, ifc.d_abort, ifc.mem_re, ifc.mem_we}, 32'h0);
        checkOutput("reset_mem_addr", ifc.mem_addr, 32'h0);
        checkOutput("reset_mem_be", {28'h0, ifc.mem_be}, 32'h0);
        checkOutput("reset_mem_wdata", ifc.mem_wdata, 32'h0);
        checkOutput("reset_rdata", ifc.if_rdata | ifc.d_rdata, 32'h0);
        rst = 1'b0;

        // Table of single accesses at minimum latency
        for (int i = 0; i < 10; i++) applyStimulus(vecs[i], i);

        // Contention: both requests held, data wins until fetch has lost STARVE_MAX times
        preloadWord(32'h0000, 32'hE5910008);
        preloadWord(32'h1014, 32'h11223344);
        @(negedge clk);
        ifc.if_req   = 1'b1;
        ifc.if_addr  = 32'h0;
        ifc.if_thumb = 1'b1;
        issueLoad(32'h1014);
        for (int g = 0; g < 10; g++) begin
            waitAck(10, cycles, seen);
            checkOutput($sformatf("starve_seen%0d", g), {31'h0, seen}, 32'h1);
            got_fetch = ifc.if_ack;
            checkOutput($sformatf("starve_grant%0d", g), {30'h0, ifc.if_ack, ifc.d_ack},
                        (g == 4 || g == 9) ? 32'h2 : 32'h1);
            if (got_fetch) checkOutput($sformatf("starve_if_rdata%0d", g), ifc.if_rdata, 32'h00000008);
            else           checkOutput($sformatf("starve_d_rdata%0d", g), ifc.d_rdata, 32'h11223344);
        end
        clearReqs();

        // Three wait states: ack three cycles after the minimum, data intact
        @(negedge clk);
        stall_req = 3;
        issueLoad(32'h1014);
        waitAck(20, cycles, seen);
        checkOutput("wait_latency", 32'(cycles), 32'd5);
        checkOutput("wait_d_ack", {31'h0, ifc.d_ack}, 32'h1);
        checkOutput("wait_d_rdata", ifc.d_rdata, 32'h11223344);
        checkOutput("wait_d_abort", {31'h0, ifc.d_abort}, 32'h0);
        clearReqs();
        stall_req = 0;

        // Stuck bus: abort after TIMEOUT_CYCLES bus cycles, then back to idle
        @(negedge clk);
        stuck = 1'b1;
        issueLoad(32'h1014);
        waitAck(40, cycles, seen);
        checkOutput("timeout_latency", 32'(cycles), 32'd17);
        checkOutput("timeout_d_ack", {31'h0, ifc.d_ack}, 32'h1);
        checkOutput("timeout_d_abort", {31'h0, ifc.d_abort}, 32'h1);
        checkOutput("timeout_d_rdata", ifc.d_rdata, 32'h0);
        checkOutput("timeout_if_ack", {31'h0, ifc.if_ack}, 32'h0);
        checkOutput("timeout_strobes", {30'h0, ifc.mem_re, ifc.mem_we}, 32'h0);
        clearReqs();
        stuck = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("timeout_idle_ack", {30'h0, ifc.d_ack, ifc.d_abort}, 32'h0);

        // Reset in the middle of a stalled access
        stuck = 1'b1;
        issueLoad(32'h1014);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        checkOutput("midreset_bus_active", {31'h0, ifc.mem_re}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midreset_async_drop", {27'h0, ifc.mem_be, ifc.mem_re}, 32'h0);
        clearReqs();
        stuck = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        stray_ack = 1'b0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            if (ifc.d_ack || ifc.if_ack) stray_ack = 1'b1;
        end
        checkOutput("midreset_no_ack", {31'h0, stray_ack}, 32'h0);
        issueLoad(32'h1015);
        waitAck(10, cycles, seen);
        checkOutput("postreset_latency", 32'(cycles), 32'd2);
        checkOutput("postreset_d_rdata", ifc.d_rdata, 32'h44112233);
        clearReqs();

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/arm7tdmi_mem_arbiter.md
Name: arm7tdmi_mem_arbiter

Overview:
Single-port memory bus controller shared by the instruction fetch unit and the load/store datapath of the ARM7TDMI core. It arbitrates between a fetch request and a data request, and drives the registered bus (addr/wdata/we/re/be) through wait states signalled by mem_ready. It also performs byte-lane steering for LDR/STR/LDRB/STRB and Thumb halfword fetch, and aborts accesses that exceed a wait-state timeout. It sits between the core pipeline and the external or simulation memory model.

Parameters:
TIMEOUT_CYCLES, 16, bus-phase cycles with mem_ready low before the access aborts (>=1)
STARVE_MAX, 4, consecutive fetch losses before fetch is granted over a pending data request (>=1)

Ports:
clk  input  1  core clock, all state on rising edge
rst  input  1  asynchronous active-high reset
if_req  input  1  fetch request, held with operands until if_ack
if_addr  input  32  fetch address
if_thumb  input  1  1 = halfword (Thumb) fetch, 0 = word fetch
if_ack  output  1  one-cycle completion pulse for fetch
if_rdata  output  32  fetched instruction, valid while if_ack=1
if_abort  output  1  qualifies if_ack: access timed out
d_req  input  1  data request, held with operands until d_ack
d_we  input  1  1 = store, 0 = load
d_byte  input  1  1 = byte access, 0 = word access
d_addr  input  32  effective address
d_wdata  input  32  store data (Rd)
d_ack  output  1  one-cycle completion pulse for data
d_rdata  output  32  load result, valid while d_ack=1
d_abort  output  1  qualifies d_ack: access timed out
mem_addr  output  32  bus address, word aligned
mem_wdata  output  32  bus write data
mem_re  output  1  bus read strobe
mem_we  output  1  bus write strobe
mem_be  output  4  byte enables
mem_rdata  input  32  bus read data, sampled when mem_ready=1
mem_ready  input  1  access completes on the rising edge where mem_ready=1

Behaviour:
- Reset (asynchronous, any state): state=IDLE; all outputs 0; timeout and starve counters 0. Any in-flight access is dropped with no ack.
- FSM states: IDLE, BUS, RESP.
- IDLE: if any request is pending, latch the winner's operands, go to BUS next edge. Otherwise stay.
- Arbitration: data wins when both requests are pending, unless starve_cnt==STARVE_MAX, in which case fetch wins. starve_cnt increments when fetch loses, clears when fetch wins, and saturates at STARVE_MAX.
- BUS: mem_re or mem_we = 1 and address/be/wdata held stable every cycle. On an edge with mem_ready=1: capture and steer rdata, go to RESP. On an edge with mem_ready=0: timeout_cnt++. If timeout_cnt reaches TIMEOUT_CYCLES-1 while still not ready, abort: go to RESP with the abort flag set and rdata=0.
- RESP: the granted requester's ack=1 for exactly one cycle, with rdata/abort valid. Bus strobes are 0. Return to IDLE next edge, timeout_cnt=0. Requests seen during RESP are ignored. The requester drops req in its ack cycle or issues a new request.
- Minimum latency: req in cycle 0, bus in cycle 1 (mem_ready=1), ack in cycle 2, IDLE in cycle 3. Each wait state adds one cycle.
- Address rule: mem_addr = {addr[31:2],2'b00} always.
- Word store: be=4'b1111, wdata=d_wdata; addr[1:0] is ignored.
- Word load: be=4'b1111, d_rdata = mem_rdata rotated right by 8*addr[1:0] (ARM unaligned load rotation).
- Byte store: be = 4'b0001 << addr[1:0], wdata = {4{d_wdata[7:0]}}.
- Byte load: be as for byte store; d_rdata = zero-extended byte lane addr[1:0].
- Word fetch: be=4'b1111, if_rdata = mem_rdata.
- Thumb fetch: be = addr[1] ? 4'b1100 : 4'b0011; if_rdata = zero-extended halfword lane addr[1]. addr[0] is ignored.
- ack, abort and rdata of the non-granted port stay 0.

Test Plan:
- Data store: d_req with d_we=1, d_byte=0, d_addr=0x1004, d_wdata=0xAABBCCDD, mem_ready=1 -> mem_we=1, mem_addr=0x1004, be=4'hF in cycle 1; d_ack in cycle 2; memory word 0x1004 = 0xAABBCCDD.
- Byte load and unaligned word load: mem[0x1014]=0x11223344. LDRB at 0x1016 -> d_rdata=0x00000022, be=4'b0100. Word load at 0x1015 -> d_rdata=0x44112233.
- Byte store: d_byte=1, d_addr=0x1013, d_wdata=0x000000AB -> be=4'b1000, mem_wdata=0xABABABAB; only byte 3 of word 0x1010 changes.
- Contention and starvation: if_req and d_req held continuously, STARVE_MAX=4 -> grants go D,D,D,D,F,D,D,D,D,F; a fetch at 0x0 with if_thumb=1, mem[0]=0xE5910008 returns if_rdata=0x00000008.
- Wait states and timeout: mem_ready low for 3 cycles then high -> ack 3 cycles later than minimum with correct data. mem_ready stuck low, TIMEOUT_CYCLES=16 -> d_ack=1, d_abort=1, d_rdata=0 after 16 bus cycles, then FSM returns to IDLE.
- Reset mid-access: rst pulsed while in BUS with mem_ready=0 -> mem_re/mem_we drop asynchronously, no ack emitted; a new request after reset completes normally.
